// File: rtl/mcycle_sequencer.sv
// Iterative multi-cycle multiply/divide unit: shift-add MUL and restoring DIV,
// one iteration per clock, sequenced by an IDLE/COMPUTE/FINISH state machine.
module mcycle_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_FINISH  = 2'd2
  } state_t;

  // Handshake: Start is a request qualified only in IDLE; Busy is the
  // combinational stall, Done a one-cycle registered pulse with results valid.

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sign1_q, sign1_d;
  logic               sign2_q, sign2_d;
  logic [WIDTH-1:0]   mag1_q, mag1_d;
  logic [WIDTH-1:0]   mag2_q, mag2_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;
  logic               done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   op1_orig;

  // acc holds {partial product, remaining multiplier} for MUL and
  // {partial remainder, remaining dividend / quotient bits} for DIV.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag1_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, mag2_q};
    div_step = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod_fix = (op_q[1] & (sign1_q ^ sign2_q)) ? -acc_q : acc_q;
    quo_fix  = (op_q[1] & (sign1_q ^ sign2_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = (op_q[1] & sign1_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    op1_orig = sign1_q ? -mag1_q : mag1_q;
  end

  always_comb begin
    op_d    = op_q;
    sign1_d = sign1_q;
    sign2_d = sign2_q;
    mag1_d  = mag1_q;
    mag2_d  = mag2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = MCycleOp;
          sign1_d = MCycleOp[1] & Operand1[WIDTH-1];
          sign2_d = MCycleOp[1] & Operand2[WIDTH-1];
          mag1_d  = sign1_d ? -Operand1 : Operand1;
          mag2_d  = sign2_d ? -Operand2 : Operand2;
          acc_d   = {{WIDTH{1'b0}}, (MCycleOp[0] ? mag1_d : mag2_d)};
          cnt_d   = '0;
        end
      end
      S_COMPUTE: begin
        acc_d = op_q[0] ? div_step : mul_step;
        cnt_d = cnt_q + CW'(1);
      end
      S_FINISH: begin
        done_d = 1'b1;
        if (!op_q[0]) begin
          res1_d = prod_fix[WIDTH-1:0];
          res2_d = prod_fix[2*WIDTH-1:WIDTH];
        end else if (mag2_q == '0) begin
          // Divide by zero returns all-ones quotient and the dividend untouched.
          res1_d = '1;
          res2_d = op1_orig;
        end else begin
          res1_d = quo_fix;
          res2_d = rem_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      op_q    <= '0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      mag1_q  <= '0;
      mag2_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res1_q  <= '0;
      res2_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      op_q    <= op_d;
      sign1_q <= sign1_d;
      sign2_q <= sign2_d;
      mag1_q  <= mag1_d;
      mag2_q  <= mag2_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      done_q  <= done_d;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (Start) state_d = S_COMPUTE;
      S_COMPUTE: if (cnt_q == CW'(WIDTH - 1)) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    Busy      = (state_q == S_IDLE) ? Start : 1'b1;
    dbg_state = state_q;
  end

  assign Result1 = res1_q;
  assign Result2 = res2_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Directed bench for mcycle_sequencer: MUL/DIV vectors, corner cases,
// back-to-back issue and mid-operation reset.
module tb_mcycle_sequencer;

  logic        CLK;
  logic        RESET;
  logic        Start;
  logic [1:0]  MCycleOp;
  logic [31:0] Operand1;
  logic [31:0] Operand2;
  logic [31:0] Result1;
  logic [31:0] Result2;
  logic        Busy;
  logic        Done;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  mcycle_sequencer #(.WIDTH(32)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .Start     (Start),
    .MCycleOp  (MCycleOp),
    .Operand1  (Operand1),
    .Operand2  (Operand2),
    .Result1   (Result1),
    .Result2   (Result2),
    .Busy      (Busy),
    .Done      (Done),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Driver: present a request for one edge, then scramble the inputs.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
    Start    = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    #1;
    check({tag, "_busy_at_start"}, 64'(Busy), 64'd1);
    busy_cnt = 1;
    step();
    Start    = 1'b0;
    Operand1 = $urandom;
    Operand2 = $urandom;
    MCycleOp = 2'($urandom_range(0, 3));
  endtask

  // Wait (bounded) for Done, pulsing a stray Start mid-compute on the way.
  task automatic wait_done(input logic [31:0] exp1, input logic [31:0] exp2, input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      if (Done) begin
        got = 1'b1;
        break;
      end
      if (Busy) busy_cnt++;
      if (n == 5) Start = 1'b1;
      if (n == 6) Start = 1'b0;
      step();
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd34);
    check({tag, "_busy_in_done"}, 64'(Busy), 64'd0);
    check({tag, "_result1"}, 64'(Result1), 64'(exp1));
    check({tag, "_result2"}, 64'(Result2), 64'(exp2));
  endtask

  task automatic after_done(input string tag);
    step();
    check({tag, "_done_pulse_ends"}, 64'(Done), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp1, input logic [31:0] exp2, input string tag);
    start_op(op, a, b, tag);
    wait_done(exp1, exp2, tag);
    after_done(tag);
  endtask

  initial begin
    bit saw_done;
    RESET    = 1'b0;
    Start    = 1'b0;
    MCycleOp = 2'b00;
    Operand1 = '0;
    Operand2 = '0;
    repeat (3) step();
    RESET = 1'b1;
    #1;
    check("reset_result1", 64'(Result1), 64'd0);
    check("reset_result2", 64'(Result2), 64'd0);
    check("reset_done", 64'(Done), 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    step();

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, "umul_max");
    run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, "smul_m3x5");
    run_op(2'b01, 32'd100, 32'd7, 32'd14, 32'd2, "udiv_100_7");
    run_op(2'b11, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, "sdiv_m100_7");
    run_op(2'b11, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, "sdiv_7_m2");
    run_op(2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, "udiv_zero");
    run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, "sdiv_zero");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, "sdiv_ovf");

    // Back-to-back: second Start issued in the Done cycle of the first.
    start_op(2'b00, 32'd6, 32'd7, "b2b_first");
    wait_done(32'd42, 32'd0, "b2b_first");
    start_op(2'b00, 32'd9, 32'd9, "b2b_second");
    check("b2b_prev_result_held", 64'(Result1), 64'd42);
    check("b2b_done_dropped", 64'(Done), 64'd0);
    wait_done(32'd81, 32'd0, "b2b_second");
    after_done("b2b_second");

    // Reset in the middle of a divide aborts it.
    start_op(2'b01, 32'd1000, 32'd3, "abort");
    repeat (9) step();
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_done", 64'(Done), 64'd0);
    check("abort_result1", 64'(Result1), 64'd0);
    check("abort_result2", 64'(Result2), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    saw_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (Done || Busy) saw_done = 1'b1;
      step();
    end
    check("abort_no_late_done", 64'(saw_done), 64'd0);

    run_op(2'b00, 32'd2, 32'd3, 32'd6, 32'd0, "post_reset_mul");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
